rf_write_arbiter: RTL and testbench

Shares the single write port (WE3/A3/WD3) of the 32 x 256-bit Register_File among several writeback sources: ALU, load unit, and vector permute unit. It performs a valid/ready handshake per requester and round-robin arbitration, then drives a registered write to the register file. Writes to x0 are accepted and dropped. A saturating counter records write-port contention.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 55 +++++
 rtl/rf_write_arbiter.sv | 86 ++++++++
 tb/tb_rf_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Register-file shared constants and types.
// Used by the write arbiter and its round-robin sub-block.
package rf_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_WIDTH  = 256;
  localparam int ADDR_WIDTH = 5;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [REG_WIDTH-1:0]  rf_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-priority encoder plus pointer.
// Ports: clk, rst, req[N], en, gnt[N] one-hot, gnt_idx.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_idx;
  logic          w_hit;
  logic [IW-1:0] w_nxt;
  int            w_j;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_hit = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!w_hit && req[w_j]) begin
        w_hit      = 1'b1;
        w_gnt[w_j] = 1'b1;
        w_idx      = IW'(w_j);
      end
    end
  end

  assign gnt     = en ? w_gnt : '0;
  assign gnt_idx = w_idx;

  always_comb begin
    w_nxt = '0;
    if (w_idx != IW'(N - 1)) w_nxt = w_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (en && |w_gnt) begin
      r_ptr <= w_nxt;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port among writeback sources.
// Ports: req_valid/ready/addr/data per source, rf_hold, WE3/A3/WD3, grant_id, conflict_cnt.
module rf_write_arbiter #(
  parameter  int NUM_REQ    = 3,
  parameter  int REG_WIDTH  = rf_pkg::REG_WIDTH,
  parameter  int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]  req_data,
  input  logic                          rf_hold,
  output logic                          WE3,
  output logic [ADDR_WIDTH-1:0]         A3,
  output logic [REG_WIDTH-1:0]          WD3,
  output logic [IDW-1:0]                grant_id,
  output logic [15:0]                   conflict_cnt
);

  import rf_pkg::*;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDW-1:0]        w_idx;
  logic                  w_en;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [REG_WIDTH-1:0]  w_data;
  logic                  w_conflict;

  // Ready is forced low during reset as well as during hold.
  assign w_en = ~rf_hold & ~rst;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_idx)
  );

  assign req_ready = w_gnt;
  assign w_xfer    = |w_gnt;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_data = req_data[i*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  assign w_conflict = $countones(req_valid) >= 2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      grant_id <= '0;
    end else if (w_xfer) begin
      // x0 writes complete the handshake but never reach the file.
      WE3      <= (w_addr != ADDR_WIDTH'(ZERO_REG));
      A3       <= w_addr;
      WD3      <= w_data;
      grant_id <= w_idx;
    end else begin
      WE3      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (w_conflict && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: vector table plus corner sequences.
// A small register file model sits on WE3/A3/WD3.
module tb_rf_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid;
  logic [2:0]   req_ready;
  logic [14:0]  req_addr;
  logic [767:0] req_data;
  logic         rf_hold;
  logic         WE3;
  logic [4:0]   A3;
  logic [255:0] WD3;
  logic [1:0]   grant_id;
  logic [15:0]  conflict_cnt;

  rf_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rf_hold      (rf_hold),
    .WE3          (WE3),
    .A3           (A3),
    .WD3          (WD3),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  logic [255:0] rf [32];
  always @(posedge clk) begin
    if (WE3 && A3 != 5'd0) rf[A3] <= WD3;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         xfer;
    logic         we;
    logic [4:0]   a;
    logic [255:0] d;
    logic [1:0]   id;
  } out_t;

  out_t         sb[$];
  int           m_ptr;
  logic [15:0]  m_cnt;
  logic [4:0]   m_a3;
  logic [255:0] m_wd3;
  logic [1:0]   m_gid;
  logic [4:0]   ta [3];
  logic [255:0] td [3];
  logic [2:0]   s_rdy;

  function automatic logic [2:0] mrdy(input logic [2:0] v,
                                      input logic h, input int p);
    logic [2:0] r;
    logic       f;
    int         j;
    r = '0;
    f = 1'b0;
    if (!h) begin
      for (int k = 0; k < 3; k++) begin
        j = (p + k) % 3;
        if (!f && v[j]) begin
          f    = 1'b1;
          r[j] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = '0;
    m_a3  = '0;
    m_wd3 = '0;
    m_gid = '0;
    sb.delete();
  endtask

  // Called just after a rising edge; ends just after the next one.
  task automatic do_cycle(input string nm);
    logic [2:0] er;
    out_t       o;
    int         gi;
    req_addr = {ta[2], ta[1], ta[0]};
    req_data = {td[2], td[1], td[0]};
    @(negedge clk);
    er    = mrdy(req_valid, rf_hold, m_ptr);
    s_rdy = req_ready;
    chk({nm, ".ready"}, 256'(req_ready), 256'(er));
    o  = '{xfer: 1'b0, we: 1'b0, a: '0, d: '0, id: '0};
    gi = -1;
    for (int i = 0; i < 3; i++) if (er[i]) gi = i;
    if (gi >= 0) begin
      o.xfer = 1'b1;
      o.we   = (ta[gi] != 5'd0);
      o.a    = ta[gi];
      o.d    = td[gi];
      o.id   = 2'(gi);
    end
    sb.push_back(o);
    @(posedge clk);
    if (gi >= 0) m_ptr = (gi + 1) % 3;
    if ($countones(req_valid) >= 2 && m_cnt != 16'hFFFF)
      m_cnt = m_cnt + 16'd1;
    #1;
    o = sb.pop_front();
    if (o.xfer) begin
      m_a3  = o.a;
      m_wd3 = o.d;
      m_gid = o.id;
    end
    chk({nm, ".WE3"}, 256'(WE3), 256'(o.we));
    chk({nm, ".A3"}, 256'(A3), 256'(m_a3));
    chk({nm, ".WD3"}, WD3, m_wd3);
    chk({nm, ".gid"}, 256'(grant_id), 256'(m_gid));
    chk({nm, ".cnt"}, 256'(conflict_cnt), 256'(m_cnt));
  endtask

  typedef struct {
    logic [2:0]  v;
    logic        h;
    logic [2:0]  rdy;
    logic [1:0]  gid;
    logic [15:0] cnt;
  } vec_t;

  vec_t         tbl [12];
  logic [255:0] pre7;

  initial begin
    tbl[0]  = '{3'b111, 1'b0, 3'b001, 2'd0, 16'd1};
    tbl[1]  = '{3'b111, 1'b0, 3'b010, 2'd1, 16'd2};
    tbl[2]  = '{3'b111, 1'b0, 3'b100, 2'd2, 16'd3};
    tbl[3]  = '{3'b111, 1'b0, 3'b001, 2'd0, 16'd4};
    tbl[4]  = '{3'b111, 1'b0, 3'b010, 2'd1, 16'd5};
    tbl[5]  = '{3'b111, 1'b0, 3'b100, 2'd2, 16'd6};
    tbl[6]  = '{3'b110, 1'b0, 3'b010, 2'd1, 16'd7};
    tbl[7]  = '{3'b011, 1'b0, 3'b001, 2'd0, 16'd8};
    tbl[8]  = '{3'b100, 1'b1, 3'b000, 2'd0, 16'd8};
    tbl[9]  = '{3'b101, 1'b0, 3'b100, 2'd2, 16'd9};
    tbl[10] = '{3'b000, 1'b0, 3'b000, 2'd2, 16'd9};
    tbl[11] = '{3'b010, 1'b0, 3'b010, 2'd1, 16'd9};

    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 3; i++) begin
      ta[i] = '0;
      td[i] = '0;
    end
    req_addr  = '0;
    req_data  = '0;
    rst       = 1'b1;
    rf_hold   = 1'b0;
    req_valid = 3'b111;
    model_reset();

    // Reset with all valids high.
    #1;
    chk("rst.ready", 256'(req_ready), 256'(3'b000));
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.ready2", 256'(req_ready), 256'(3'b000));
    chk("rst.WE3", 256'(WE3), 256'(1'b0));
    chk("rst.cnt", 256'(conflict_cnt), 256'(16'd0));
    chk("rst.gid", 256'(grant_id), 256'(2'd0));
    rst = 1'b0;
    #1;
    chk("rel.ready", 256'(req_ready), 256'(3'b001));

    // Vector table; row addresses are never x0.
    for (int r = 0; r < 12; r++) begin
      req_valid = tbl[r].v;
      rf_hold   = tbl[r].h;
      for (int i = 0; i < 3; i++) begin
        ta[i] = 5'((r * 3 + i) % 31 + 1);
        td[i] = {8{32'h1000_0000 + 32'(r * 4 + i)}};
      end
      do_cycle($sformatf("tbl%0d", r));
      chk($sformatf("tbl%0d.rdy", r), 256'(s_rdy), 256'(tbl[r].rdy));
      chk($sformatf("tbl%0d.gid", r), 256'(grant_id), 256'(tbl[r].gid));
      chk($sformatf("tbl%0d.cnt", r), 256'(conflict_cnt),
          256'(tbl[r].cnt));
    end

    // Single requester 1 writes r3, read back two cycles on.
    req_valid = 3'b010;
    ta[1]     = 5'd3;
    td[1]     = {8{32'hAAAABEEF}};
    do_cycle("w3");
    chk("w3.we", 256'(WE3), 256'(1'b1));
    chk("w3.a3", 256'(A3), 256'(5'd3));
    req_valid = 3'b000;
    do_cycle("w3.idle");
    chk("w3.rd", rf[3], {8{32'hAAAABEEF}});

    // x0 write is accepted but dropped.
    req_valid = 3'b001;
    ta[0]     = 5'd0;
    td[0]     = {8{32'hCAFEBABE}};
    do_cycle("x0");
    chk("x0.rdy", 256'(s_rdy), 256'(3'b001));
    chk("x0.we", 256'(WE3), 256'(1'b0));
    req_valid = 3'b000;
    do_cycle("x0.idle");
    chk("x0.rd", rf[0], 256'd0);

    // Hold for three cycles with requester 2 valid.
    req_valid = 3'b100;
    ta[2]     = 5'd9;
    td[2]     = {8{32'h0BAD_F00D}};
    rf_hold   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      do_cycle($sformatf("hold%0d", c));
      chk($sformatf("hold%0d.rdy", c), 256'(s_rdy), 256'(3'b000));
    end
    rf_hold = 1'b0;
    do_cycle("unhold");
    chk("unhold.rdy", 256'(s_rdy), 256'(3'b100));
    req_valid = 3'b111;
    ta[0] = 5'd10;
    ta[1] = 5'd11;
    do_cycle("after.hold");
    chk("after.hold.rdy", 256'(s_rdy), 256'(3'b001));

    // Reset right after a grant to r7 discards the write.
    pre7      = rf[7];
    req_valid = 3'b001;
    ta[0]     = 5'd7;
    td[0]     = {8{32'h7777_0007}};
    do_cycle("r7");
    chk("r7.we", 256'(WE3), 256'(1'b1));
    req_valid = 3'b000;
    rst       = 1'b1;
    #1;
    chk("r7.rst.we", 256'(WE3), 256'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    do_cycle("r7.idle");
    chk("r7.rd", rf[7], pre7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
